veda_arb: RTL and testbench
===========================

# veda_arb

Two-port round-robin controller that shares the single `veda` register bank between two independent requesters. Each requester issues write or read/mode commands over a valid/ready handshake. The block serialises them onto veda's `mode`/`we`/`addr_a`/`addr_b`/`data_in` pins, captures `data_out` for reads, and returns it on a per-requester response handshake. It sits directly in front of `veda`, and nothing else drives veda's command pins.

## Interface
- `DATA_W`, 32: data width, matches veda `data_in`/`data_out`.
- `ADDR_W`, 5: register address width, matches veda `addr_a`/`addr_b`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid[1:0]` in 2: command valid, one bit per requester i.
- `req_ready[1:0]` out 2: command accepted on this edge when `valid && ready`.
- `req_we[1:0]` in 2: 1 = write, 0 = read.
- `req_mode[1:0]` in 2: passed to veda `mode`.
- `req_addr_a0`, `req_addr_a1` in ADDR_W: requester i's `addr_a`.
- `req_addr_b0`, `req_addr_b1` in ADDR_W: requester i's `addr_b`.
- `req_wdata0`, `req_wdata1` in DATA_W: requester i's write data.
- `rsp_valid[1:0]` out 2: read data valid for requester i.
- `rsp_ready[1:0]` in 2: requester i consumes the response.
- `rsp_data` out DATA_W: shared response data, meaningful only where `rsp_valid[i]` is high.
- `busy` out 1: high in any state other than IDLE.
- `grant_cnt0`, `grant_cnt1` out 16: commands accepted per requester, wrap at 2^16.
- `v_mode`, `v_we` out 1 each: registered command pins to veda.
- `v_addr_a`, `v_addr_b` out ADDR_W: registered addresses to veda.
- `v_data_in` out DATA_W: registered write data to veda.
- `v_data_out` in DATA_W: veda read data, valid in the cycle after a command with `we=0`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - If any `req_valid` is high, arbitrate and assert `req_ready` for the winner only. This is combinational, in IDLE only.
  - On the handshake edge, register the winner's command onto the `v_*` pins, increment its `grant_cnt`, record the winner index, then go to ISSUE.
- **ISSUE**: the `v_*` pins hold the command for exactly one cycle.
  - If `we=1`, return to IDLE and drop `v_we` to 0.
  - If `we=0`, go to CAPTURE.
- **CAPTURE**: `v_we=0`. On the exit edge, latch `v_data_out` into `rsp_data`, then go to RESP.
- **RESP**
  - `rsp_valid[winner]` is high and `rsp_data` is stable.
  - On the edge with `rsp_ready[winner]` high, clear `rsp_valid` and go to IDLE.
  - Writes produce no response.
- **Arbitration**
  - Round-robin over two requesters with a single priority bit `last`.
  - When both are valid, the requester other than `last` wins. A lone requester always wins.
  - `last` updates only on the accept edge.
- **Idle pin values**: outside ISSUE, `v_we=0`. `v_mode`, `v_addr_*` and `v_data_in` hold their last value, so no spurious writes occur.
- **Reset mid-operation**
  - All state returns to IDLE and any in-flight response is dropped.
  - `last` resets to 1, so requester 0 wins the first contention.
  - Counters return to 0. No veda write is issued during or after reset until a new accept.

## Timing
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `busy=0`.
  - `grant_cnt*=0`.
  - All `v_*` outputs are 0.
- Write: accept at edge T, then `v_we=1` during cycle T..T+1, and veda writes at edge T+1. `req_ready` can be high again in the cycle after edge T+1, so the next accept is at edge T+2 at the earliest. Throughput is one write per 2 cycles.
- Read: accept at edge T, command visible T..T+1, `rsp_data` captured at edge T+2, `rsp_valid` high from T+2. With `rsp_ready` held high, RESP exits at T+3. Minimum spacing is 4 cycles.
- `req_valid` may drop without handshake. No command is lost, because acceptance occurs only on a `valid && ready` edge.
- The `busy` rising edge coincides with the accept edge.

## Structure
- Package `veda_pkg` holds:
  - the `veda_state_t` enum (IDLE/ISSUE/CAPTURE/RESP);
  - `VEDA_DATA_W=32`, `VEDA_ADDR_W=5`;
  - a packed `veda_cmd_t` struct {mode, we, addr_a, addr_b, data}.
- Sub-module `rr_arb2`: inputs `req[1:0]` and `last`; output one-hot `gnt[1:0]`. Purely combinational. The `last` register stays in `veda_arb`.

## Test plan
- **Reset then single write**: after `rst` falls, requester 0 writes addr_a=3, addr_b=4, data=10, mode=0. Expected: `req_ready[0]` high in the IDLE cycle, then `v_we=1` with `v_addr_a=3`, `v_data_in=10` for exactly one cycle, then `grant_cnt0=1`.
- **Read latency**: requester 1 reads (we=0, mode=1, addr_a=3) with `rsp_ready` held high. Expected: `rsp_valid[1]` rises 2 edges after accept, `rsp_data` equals the veda model value, and it falls 1 edge later.
- **Contention**: both requesters hold `req_valid` high with writes data=10 and data=11 for 4 commands each. Expected: grants alternate 0,1,0,1,… and end with `grant_cnt0=grant_cnt1=4`.
- **Response backpressure**: read with `rsp_ready` low for 5 cycles. Expected: `rsp_valid` and `rsp_data` stay stable, both `req_ready` bits stay 0, and `busy=1` until the ready edge.
- **Reset mid-read**: assert `rst` during CAPTURE. Expected: immediately all outputs return to reset values with `v_we=0`. After release, the first contention goes to requester 0.

Source files
------------

// File: rtl/veda_pkg.sv
// Shared types and widths for the veda register-bank front end.
package veda_pkg;

    localparam int VEDA_DATA_W = 32;
    localparam int VEDA_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } veda_state_t;

    typedef struct packed {
        logic                   mode;
        logic                   we;
        logic [VEDA_ADDR_W-1:0] addr_a;
        logic [VEDA_ADDR_W-1:0] addr_b;
        logic [VEDA_DATA_W-1:0] data;
    } veda_cmd_t;

endpackage

// File: rtl/veda_arb_if.sv
// Two-requester command/response bundle in front of veda.
interface veda_arb_if
    import veda_pkg::*;
#(
    parameter int DATA_W = VEDA_DATA_W,
    parameter int ADDR_W = VEDA_ADDR_W
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0]        req_mode;
    logic [ADDR_W-1:0] req_addr_a0;
    logic [ADDR_W-1:0] req_addr_a1;
    logic [ADDR_W-1:0] req_addr_b0;
    logic [ADDR_W-1:0] req_addr_b1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_mode, req_addr_a0, req_addr_a1,
               req_addr_b0, req_addr_b1, req_wdata0, req_wdata1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_mode, req_addr_a0, req_addr_a1,
               req_addr_b0, req_addr_b1, req_wdata0, req_wdata1, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester other than last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/veda_arb.sv
// Serialises two requesters' commands onto veda's pins and returns read data.
module veda_arb
    import veda_pkg::*;
#(
    parameter int DATA_W = VEDA_DATA_W,
    parameter int ADDR_W = VEDA_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    veda_arb_if.slave         bus,
    output logic              busy,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic              v_mode,
    output logic              v_we,
    output logic [ADDR_W-1:0] v_addr_a,
    output logic [ADDR_W-1:0] v_addr_b,
    output logic [DATA_W-1:0] v_data_in,
    input  logic [DATA_W-1:0] v_data_out
);
    localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
    localparam logic [1:0] S_ISSUE   = 2'(ST_ISSUE);
    localparam logic [1:0] S_CAPTURE = 2'(ST_CAPTURE);
    localparam logic [1:0] S_RESP    = 2'(ST_RESP);

    logic [1:0]        state_q;
    logic              last_q;
    logic              winner_q;
    veda_cmd_t         cmd_q;
    veda_cmd_t         cmd_sel;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        gnt;
    logic [1:0]        ready;
    logic              gnt_idx;
    logic              accept;

    rr_arb2 u_arb (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    // Grants are only offered in IDLE; reset masks them so req_ready reads 0.
    assign ready   = (state_q == S_IDLE && !rst) ? gnt : 2'b00;
    assign gnt_idx = gnt[1];
    assign accept  = |(bus.req_valid & ready);

    always_comb begin
        cmd_sel = '0;
        if (gnt_idx) begin
            cmd_sel.mode   = bus.req_mode[1];
            cmd_sel.we     = bus.req_we[1];
            cmd_sel.addr_a = bus.req_addr_a1;
            cmd_sel.addr_b = bus.req_addr_b1;
            cmd_sel.data   = bus.req_wdata1;
        end else begin
            cmd_sel.mode   = bus.req_mode[0];
            cmd_sel.we     = bus.req_we[0];
            cmd_sel.addr_a = bus.req_addr_a0;
            cmd_sel.addr_b = bus.req_addr_b0;
            cmd_sel.data   = bus.req_wdata0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            winner_q    <= 1'b0;
            cmd_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            grant_cnt0  <= 16'd0;
            grant_cnt1  <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q    <= cmd_sel;
                        winner_q <= gnt_idx;
                        last_q   <= gnt_idx;
                        if (gnt_idx) grant_cnt1 <= grant_cnt1 + 16'd1;
                        else         grant_cnt0 <= grant_cnt0 + 16'd1;
                        state_q  <= S_ISSUE;
                    end
                end
                // Command held for exactly one cycle; we is dropped so the
                // remaining pins can sit on the bus without re-writing.
                S_ISSUE: begin
                    cmd_q.we <= 1'b0;
                    state_q  <= cmd_q.we ? S_IDLE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_data_q  <= v_data_out;
                    rsp_valid_q <= winner_q ? 2'b10 : 2'b01;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready[winner_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != S_IDLE);
    assign v_mode        = cmd_q.mode;
    assign v_we          = cmd_q.we;
    assign v_addr_a      = cmd_q.addr_a;
    assign v_addr_b      = cmd_q.addr_b;
    assign v_data_in     = cmd_q.data;
endmodule

// File: tb/tb_veda_arb.sv
// Directed bench for veda_arb with a small registered veda register-bank model.
module tb_veda_arb;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] grant_cnt0, grant_cnt1;
    logic        v_mode, v_we;
    logic [4:0]  v_addr_a, v_addr_b;
    logic [31:0] v_data_in, v_data_out;
    logic [31:0] regs [32];
    int          tests = 0;
    int          fails = 0;

    veda_arb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    veda_arb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .v_mode     (v_mode),
        .v_we       (v_we),
        .v_addr_a   (v_addr_a),
        .v_addr_b   (v_addr_b),
        .v_data_in  (v_data_in),
        .v_data_out (v_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // veda model: write addr_a on we, registered read of addr_a every cycle
    initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    always @(posedge clk) begin
        if (v_we) regs[v_addr_a] <= v_data_in;
        v_data_out <= regs[v_addr_a];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = 2'b00;
        bus.req_we      = 2'b00;
        bus.req_mode    = 2'b00;
        bus.req_addr_a0 = '0;
        bus.req_addr_a1 = '0;
        bus.req_addr_b0 = '0;
        bus.req_addr_b1 = '0;
        bus.req_wdata0  = '0;
        bus.req_wdata1  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.rsp_ready = 2'b00;
        step();
        step();
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
        tests++; if (bus.rsp_data !== 32'd0) begin fails++; $display("FAIL reset_rsp_data got %0d want 0", bus.rsp_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if ({grant_cnt0, grant_cnt1} !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", grant_cnt0, grant_cnt1); end
        tests++; if ({v_mode, v_we, v_addr_a, v_addr_b, v_data_in} !== 44'd0) begin fails++; $display("FAIL reset_vpins got we=%b a=%0d d=%0d want 0", v_we, v_addr_a, v_data_in); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        bus.req_valid = 2'b01; bus.req_we = 2'b01; bus.req_mode = 2'b00;
        bus.req_addr_a0 = 5'd3; bus.req_addr_b0 = 5'd4; bus.req_wdata0 = 32'd10;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL wr_ready got %b want 01", bus.req_ready); end
        step();
        tests++; if (v_we !== 1'b1 || v_addr_a !== 5'd3 || v_addr_b !== 5'd4 || v_data_in !== 32'd10) begin fails++; $display("FAIL wr_pins got we=%b a=%0d b=%0d d=%0d want 1/3/4/10", v_we, v_addr_a, v_addr_b, v_data_in); end
        tests++; if (grant_cnt0 !== 16'd1 || busy !== 1'b1) begin fails++; $display("FAIL wr_cnt got cnt0=%0d busy=%b want 1/1", grant_cnt0, busy); end
        tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL wr_ready_issue got %b want 00", bus.req_ready); end
        bus.req_valid = 2'b00;
        step();
        tests++; if (v_we !== 1'b0 || busy !== 1'b0 || v_addr_a !== 5'd3) begin fails++; $display("FAIL wr_one_cycle got we=%b busy=%b a=%0d want 0/0/3", v_we, busy, v_addr_a); end
        tests++; if (regs[3] !== 32'd10) begin fails++; $display("FAIL wr_bank got %0d want 10", regs[3]); end
    endtask

    task automatic test_read_latency();
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10; bus.req_we = 2'b00; bus.req_mode = 2'b10;
        bus.req_addr_a1 = 5'd3; bus.req_addr_b1 = 5'd0;
        #1;
        tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL rd_ready got %b want 10", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        tests++; if (v_mode !== 1'b1 || v_we !== 1'b0 || bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL rd_issue got mode=%b we=%b rv=%b want 1/0/00", v_mode, v_we, bus.rsp_valid); end
        step();
        tests++; if (bus.rsp_valid !== 2'b00) begin fails++; $display("FAIL rd_early got %b want 00", bus.rsp_valid); end
        step();
        tests++; if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'd10) begin fails++; $display("FAIL rd_data got rv=%b d=%0d want 10/10", bus.rsp_valid, bus.rsp_data); end
        step();
        tests++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0 || grant_cnt1 !== 16'd1) begin fails++; $display("FAIL rd_done got rv=%b busy=%b cnt1=%0d want 00/0/1", bus.rsp_valid, busy, grant_cnt1); end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        bus.req_valid = 2'b11; bus.req_we = 2'b11; bus.req_mode = 2'b00;
        bus.req_addr_a0 = 5'd5; bus.req_wdata0 = 32'd10;
        bus.req_addr_a1 = 5'd6; bus.req_wdata1 = 32'd11;
        #1;
        for (int k = 0; k < 8; k++) begin
            int budget = 0;
            while (bus.req_ready == 2'b00 && budget < 6) begin
                step();
                budget++;
            end
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (bus.req_ready !== exp) begin fails++; $display("FAIL cont_grant%0d got %b want %b", k, bus.req_ready, exp); end
            step();
        end
        bus.req_valid = 2'b00;
        step();
        step();
        tests++; if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd5) begin fails++; $display("FAIL cont_cnt got %0d/%0d want 5/5", grant_cnt0, grant_cnt1); end
        tests++; if (regs[5] !== 32'd10 || regs[6] !== 32'd11) begin fails++; $display("FAIL cont_bank got %0d/%0d want 10/11", regs[5], regs[6]); end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01; bus.req_we = 2'b00; bus.req_mode = 2'b00;
        bus.req_addr_a0 = 5'd6;
        #1;
        step();
        bus.req_valid = 2'b10;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'd11) begin fails++; $display("FAIL bp_rsp%0d got rv=%b d=%0d want 01/11", c, bus.rsp_valid, bus.rsp_data); end
            tests++; if (bus.req_ready !== 2'b00 || busy !== 1'b1) begin fails++; $display("FAIL bp_hold%0d got rdy=%b busy=%b want 00/1", c, bus.req_ready, busy); end
            step();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        step();
        tests++; if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL bp_release got rv=%b busy=%b want 00/0", bus.rsp_valid, busy); end
    endtask

    task automatic test_reset_mid_read();
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10; bus.req_we = 2'b00;
        bus.req_addr_a1 = 5'd5;
        #1;
        step();
        bus.req_valid = 2'b00;
        step();
        rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_data !== 32'd0) begin fails++; $display("FAIL mid_rst_state got busy=%b rv=%b d=%0d want 0/00/0", busy, bus.rsp_valid, bus.rsp_data); end
        tests++; if ({grant_cnt0, grant_cnt1} !== 32'd0 || {v_mode, v_we, v_addr_a, v_addr_b, v_data_in} !== 44'd0) begin fails++; $display("FAIL mid_rst_out got cnt=%0d/%0d we=%b a=%0d want 0", grant_cnt0, grant_cnt1, v_we, v_addr_a); end
        step();
        step();
        tests++; if (bus.rsp_valid !== 2'b00 || v_we !== 1'b0) begin fails++; $display("FAIL mid_rst_hold got rv=%b we=%b want 00/0", bus.rsp_valid, v_we); end
        rst = 1'b0;
        step();
        bus.req_valid = 2'b11; bus.req_we = 2'b11;
        bus.req_addr_a0 = 5'd7; bus.req_wdata0 = 32'd10;
        bus.req_addr_a1 = 5'd8; bus.req_wdata1 = 32'd11;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL post_rst_grant got %b want 01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        tests++; if (v_we !== 1'b1 || v_addr_a !== 5'd7 || grant_cnt0 !== 16'd1 || grant_cnt1 !== 16'd0) begin fails++; $display("FAIL post_rst_cmd got we=%b a=%0d cnt=%0d/%0d want 1/7/1/0", v_we, v_addr_a, grant_cnt0, grant_cnt1); end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_contention();
        test_backpressure();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
